// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register and IF/ID pipeline register with stall, redirect/flush and saturating stall counter
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_load,
  input  logic                 ifid_load,
  input  logic                 ifid_flush,
  input  logic [1:0]           pc_src,
  input  logic [31:0]          branch_target,
  input  logic [31:0]          jump_target,
  input  logic [31:0]          jr_target,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          pc,
  output logic [31:0]          instr_id,
  output logic [31:0]          pc_plus4_id,
  output logic                 valid_id,
  output logic [CNT_WIDTH-1:0] stall_count
);
  logic [31:0] pcPlus4, nextPc;
  assign imem_addr = pc;
  always_comb begin
    pcPlus4 = pc + 32'd4;
    nextPc = pc_src == 2'd0 ? pcPlus4 :
             pc_src == 2'd1 ? branch_target :
             pc_src == 2'd2 ? jump_target : jr_target;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      instr_id <= '0;
      pc_plus4_id <= '0;
      valid_id <= 1'b0;
      stall_count <= '0;
    end else begin
      if (pc_load) pc <= {nextPc[31:2], 2'b00};
      // stall wins over flush: a held IF/ID keeps the branch for re-evaluation
      if (ifid_load) begin
        instr_id <= ifid_flush ? 32'h0 : imem_rdata;
        pc_plus4_id <= ifid_flush ? 32'h0 : pcPlus4;
        valid_id <= !ifid_flush;
      end
      if (!pc_load && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: directed bench with a behavioural fetch model checked every cycle
module tb_fetch_stage_ctrl;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, rst = 1, pc_load = 0, ifid_load = 0, ifid_flush = 0;
  logic [1:0] pc_src = 0;
  logic [31:0] branch_target = 0, jump_target = 0, jr_target = 0;
  logic [31:0] imemAddrA, imemAddrB, pcA, pcB, instrA, instrB, pp4A, pp4B;
  logic validA, validB;
  logic [15:0] cntA;
  logic [2:0] cntB;
  logic [31:0] mPc, mInstr, mPp4;
  logic mValid;
  int mCnt16, mCnt3;
  int checks = 0, errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl dutA (
    .clk(clk), .rst(rst), .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_addr(imemAddrA), .imem_rdata(imemAddrA ^ K), .pc(pcA), .instr_id(instrA),
    .pc_plus4_id(pp4A), .valid_id(validA), .stall_count(cntA));

  fetch_stage_ctrl #(.CNT_WIDTH(3)) dutB (
    .clk(clk), .rst(rst), .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_addr(imemAddrB), .imem_rdata(imemAddrB ^ K), .pc(pcB), .instr_id(instrB),
    .pc_plus4_id(pp4B), .valid_id(validB), .stall_count(cntB));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // model: IF/ID captures the word at the old PC, then the PC moves to its target
  always @(posedge clk) begin
    if (rst) begin
      mPc = 32'h0; mInstr = 0; mPp4 = 0; mValid = 0; mCnt16 = 0; mCnt3 = 0;
    end else begin
      if (ifid_load) begin
        mValid = !ifid_flush;
        mInstr = ifid_flush ? 32'h0 : mPc ^ K;
        mPp4 = ifid_flush ? 32'h0 : mPc + 32'd4;
      end
      if (!pc_load) begin
        mCnt16 = mCnt16 < 65535 ? mCnt16 + 1 : mCnt16;
        mCnt3 = mCnt3 < 7 ? mCnt3 + 1 : mCnt3;
      end else begin
        case (pc_src)
          2'd0: mPc = mPc + 32'd4;
          2'd1: mPc = branch_target;
          2'd2: mPc = jump_target;
          default: mPc = jr_target;
        endcase
        mPc[1:0] = 2'b00;
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("pc", pcA, mPc);
    chk("imem_addr", imemAddrA, mPc);
    chk("instr_id", instrA, mInstr);
    chk("pc_plus4_id", pp4A, mPp4);
    chk("valid_id", {31'b0, validA}, {31'b0, mValid});
    chk("stall_count16", {16'b0, cntA}, mCnt16);
    chk("pc_w3", pcB, mPc);
    chk("instr_id_w3", instrB, mInstr);
    chk("valid_id_w3", {31'b0, validB}, {31'b0, mValid});
    chk("stall_count3", {29'b0, cntB}, mCnt3);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic setc(input logic pl, input logic il, input logic fl, input logic [1:0] src);
    pc_load = pl; ifid_load = il; ifid_flush = fl; pc_src = src;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      {pc_load, ifid_load, ifid_flush} = 3'($urandom);
      pc_src = 2'($urandom);
      branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      cyc();
      started = 1;
    end
    chk("rst_pc", pcA, 32'h0);
    chk("rst_valid", {31'b0, validA}, 32'h0);
    chk("rst_instr", instrA, 32'h0);
    chk("rst_cnt", {16'b0, cntA}, 32'h0);
    rst = 0;
    setc(1, 1, 0, 0);
    cyc();
    chk("seq_pc4", pcA, 32'h4);
    chk("seq_instr0", instrA, 32'hA5A5_0000);
    chk("seq_pp4_4", pp4A, 32'h4);
    cyc();
    chk("seq_pc8", pcA, 32'h8);
    chk("seq_instr4", instrA, 32'hA5A5_0004);
    setc(0, 0, 0, 0);
    cyc(); cyc();
    chk("stall_pc", pcA, 32'h8);
    chk("stall_instr", instrA, 32'hA5A5_0004);
    chk("stall_pp4", pp4A, 32'h8);
    chk("stall_cnt", {16'b0, cntA}, 32'd2);
    setc(1, 1, 0, 0);
    cyc();
    chk("resume_pc", pcA, 32'hC);
    chk("resume_instr", instrA, 32'hA5A5_0008);
    branch_target = 32'h40;
    setc(1, 1, 1, 1);
    cyc();
    chk("br_pc", pcA, 32'h40);
    chk("br_bubble_valid", {31'b0, validA}, 32'h0);
    chk("br_bubble_instr", instrA, 32'h0);
    setc(1, 1, 0, 0);
    cyc();
    chk("br_target_instr", instrA, 32'hA5A5_0040);
    chk("br_target_valid", {31'b0, validA}, 32'h1);
    jump_target = 32'h200;
    setc(0, 0, 1, 2);
    cyc();
    chk("sf_pc", pcA, 32'h44);
    chk("sf_instr", instrA, 32'hA5A5_0040);
    chk("sf_valid", {31'b0, validA}, 32'h1);
    jr_target = 32'h103;
    setc(1, 1, 1, 3);
    cyc();
    chk("jr_pc_aligned", pcA, 32'h100);
    setc(1, 1, 0, 0);
    cyc();
    setc(1, 0, 0, 0);
    cyc();
    setc(0, 1, 0, 1);
    cyc();
    branch_target = 32'hFFFF_FFFC;
    setc(1, 1, 0, 1);
    cyc();
    setc(1, 1, 0, 0);
    cyc();
    chk("wrap_pc", pcA, 32'h0);
    chk("wrap_pp4", pp4A, 32'h0);
    setc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc();
    chk("sat_cnt3", {29'b0, cntB}, 32'd7);
    rst = 1;
    cyc();
    chk("midrst_pc", pcB, 32'h0);
    chk("midrst_cnt3", {29'b0, cntB}, 32'h0);
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      pc_load = ($urandom_range(0, 3) != 0);
      ifid_load = ($urandom_range(0, 3) != 0);
      ifid_flush = ($urandom_range(0, 3) == 0);
      pc_src = 2'($urandom);
      branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      cyc();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
